// File: rtl/decode_queue_if.sv
// Fetch/dispatch-facing signal bundle for decode_queue.
// The master side is fetch plus dispatch; the slave side is the queue itself.
interface decode_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic [1:0]    enq_cnt;
  logic [31:0]   enq_inst1;
  logic [31:0]   enq_inst2;
  logic [31:0]   enq_pc;
  logic          enq_ready;
  logic          deq_valid1;
  logic          deq_valid2;
  logic [31:0]   deq_inst1;
  logic [31:0]   deq_inst2;
  logic [31:0]   deq_pc1;
  logic [31:0]   deq_pc2;
  logic [1:0]    deq_cnt;
  logic [CW-1:0] count;

  modport master (
    output flush, enq_cnt, enq_inst1, enq_inst2, enq_pc, deq_cnt,
    input  enq_ready, deq_valid1, deq_valid2, deq_inst1, deq_inst2,
           deq_pc1, deq_pc2, count
  );

  modport slave (
    input  flush, enq_cnt, enq_inst1, enq_inst2, enq_pc, deq_cnt,
    output enq_ready, deq_valid1, deq_valid2, deq_inst1, deq_inst2,
           deq_pc1, deq_pc2, count
  );
endinterface

// File: rtl/decode_queue.sv
// Two-wide circular instruction queue between fetch and the paired decoders.
// Enqueues and retires 0-2 instructions per cycle; flush empties it without clearing storage.
module decode_queue #(
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  decode_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] head_nx, tail_nx;
  logic [CW-1:0] count_q, count_d;
  logic          enq_ok, valid1, valid2;
  logic [1:0]    avail, enq_eff, deq_eff;

  assign head_nx = head_q + PW'(1);
  assign tail_nx = tail_q + PW'(1);
  assign enq_ok  = (count_q <= CW'(DEPTH - 2));
  assign valid1  = (count_q != '0);
  assign valid2  = (count_q >= CW'(2));
  assign avail   = {1'b0, valid1} + {1'b0, valid2};

  // Outputs depend only on registered state, never on this cycle's enq/deq counts.
  assign q.enq_ready  = enq_ok;
  assign q.deq_valid1 = valid1;
  assign q.deq_valid2 = valid2;
  assign q.deq_inst1  = valid1 ? inst_q[head_q]  : NOP;
  assign q.deq_inst2  = valid2 ? inst_q[head_nx] : NOP;
  assign q.deq_pc1    = valid1 ? pc_q[head_q]    : 32'd0;
  assign q.deq_pc2    = valid2 ? pc_q[head_nx]   : 32'd0;
  assign q.count      = count_q;

  always_comb begin
    enq_eff = 2'd0;
    if (enq_ok && !q.flush && (q.enq_cnt == 2'd1 || q.enq_cnt == 2'd2))
      enq_eff = q.enq_cnt;
    deq_eff = (q.deq_cnt > avail) ? avail : q.deq_cnt;

    inst_d  = inst_q;
    pc_d    = pc_q;
    head_d  = head_q + PW'(deq_eff);
    tail_d  = tail_q + PW'(enq_eff);
    count_d = count_q + CW'(enq_eff) - CW'(deq_eff);

    if (enq_eff != 2'd0) begin
      inst_d[tail_q] = q.enq_inst1;
      pc_d[tail_q]   = q.enq_pc;
    end
    if (enq_eff == 2'd2) begin
      inst_d[tail_nx] = q.enq_inst2;
      pc_d[tail_nx]   = q.enq_pc + 32'd4;
    end

    // Flush discards this cycle's dequeue; enqueue is already suppressed above.
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= NOP;
        pc_q[i]   <= 32'd0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Table-driven check of decode_queue (DEPTH=8) plus hand sequences for
// combinational isolation and mid-stream reset.
module tb_decode_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        flush;
    logic [1:0]  enq_cnt;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] pc;
    logic [1:0]  deq_cnt;
    logic        e_ready;
    logic        e_v1;
    logic        e_v2;
    logic [31:0] e_i1;
    logic [31:0] e_i2;
    logic [31:0] e_pc1;
    logic [31:0] e_pc2;
    logic [3:0]  e_count;
  } vec_t;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  vec_t vecs[$];

  decode_queue_if #(.DEPTH(8)) bus ();

  decode_queue #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ready, input logic e_v1, input logic e_v2,
                           input logic [31:0] e_i1, input logic [31:0] e_i2,
                           input logic [31:0] e_pc1, input logic [31:0] e_pc2, input logic [3:0] e_count);
    check_output({tag, ".enq_ready"},  32'(bus.enq_ready),  32'(e_ready));
    check_output({tag, ".deq_valid1"}, 32'(bus.deq_valid1), 32'(e_v1));
    check_output({tag, ".deq_valid2"}, 32'(bus.deq_valid2), 32'(e_v2));
    check_output({tag, ".deq_inst1"},  bus.deq_inst1, e_i1);
    check_output({tag, ".deq_inst2"},  bus.deq_inst2, e_i2);
    check_output({tag, ".deq_pc1"},    bus.deq_pc1,   e_pc1);
    check_output({tag, ".deq_pc2"},    bus.deq_pc2,   e_pc2);
    check_output({tag, ".count"},      32'(bus.count), 32'(e_count));
  endtask

  // Drives one cycle of inputs, then samples 1 time unit after the edge.
  task automatic apply_stimulus(input logic fl, input logic [1:0] ec, input logic [31:0] i1,
                                input logic [31:0] i2, input logic [31:0] pc, input logic [1:0] dc);
    bus.flush     = fl;
    bus.enq_cnt   = ec;
    bus.enq_inst1 = i1;
    bus.enq_inst2 = i2;
    bus.enq_pc    = pc;
    bus.deq_cnt   = dc;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fl, input logic [1:0] ec, input logic [31:0] i1, input logic [31:0] i2,
                     input logic [31:0] pc, input logic [1:0] dc, input logic rdy, input logic v1,
                     input logic v2, input logic [31:0] o1, input logic [31:0] o2,
                     input logic [31:0] p1, input logic [31:0] p2, input logic [3:0] cnt);
    vec_t v;
    v.flush = fl; v.enq_cnt = ec; v.i1 = i1; v.i2 = i2; v.pc = pc; v.deq_cnt = dc;
    v.e_ready = rdy; v.e_v1 = v1; v.e_v2 = v2; v.e_i1 = o1; v.e_i2 = o2;
    v.e_pc1 = p1; v.e_pc2 = p2; v.e_count = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // fl ec  inst1          inst2          pc             dc   | rdy v1 v2 inst1          inst2          pc1            pc2            cnt
    add(0, 2, 32'h00500093, 32'h00A00113, 32'h00000100, 0,   1, 1, 1, 32'h00500093, 32'h00A00113, 32'h00000100, 32'h00000104, 2); // v0
    add(0, 1, 32'h00308193, 32'h0,        32'h00000108, 0,   1, 1, 1, 32'h00500093, 32'h00A00113, 32'h00000100, 32'h00000104, 3); // v1
    add(0, 0, 32'h0,        32'h0,        32'h0,        1,   1, 1, 1, 32'h00A00113, 32'h00308193, 32'h00000104, 32'h00000108, 2); // v2 partial deq
    add(0, 0, 32'h0,        32'h0,        32'h0,        2,   1, 0, 0, NOP,          NOP,          32'h0,        32'h0,        0); // v3 drain
    add(0, 1, 32'h11111111, 32'h0,        32'h00000200, 0,   1, 1, 0, 32'h11111111, NOP,          32'h00000200, 32'h0,        1); // v4
    add(0, 0, 32'h0,        32'h0,        32'h0,        2,   1, 0, 0, NOP,          NOP,          32'h0,        32'h0,        0); // v5 over-request
    add(0, 3, 32'hEEEEEEEE, 32'hEEEEEEEF, 32'h00000300, 0,   1, 0, 0, NOP,          NOP,          32'h0,        32'h0,        0); // v6 illegal cnt
    add(0, 2, 32'h22220001, 32'h22220002, 32'h00000400, 0,   1, 1, 1, 32'h22220001, 32'h22220002, 32'h00000400, 32'h00000404, 2); // v7
    add(0, 1, 32'h22220003, 32'h0,        32'h00000408, 2,   1, 1, 0, 32'h22220003, NOP,          32'h00000408, 32'h0,        1); // v8
    add(0, 0, 32'h0,        32'h0,        32'h0,        1,   1, 0, 0, NOP,          NOP,          32'h0,        32'h0,        0); // v9 head=tail=7
    add(0, 2, 32'hAAAA0001, 32'hAAAA0002, 32'h00000800, 0,   1, 1, 1, 32'hAAAA0001, 32'hAAAA0002, 32'h00000800, 32'h00000804, 2); // v10 wrap
    add(0, 0, 32'h0,        32'h0,        32'h0,        1,   1, 1, 0, 32'hAAAA0002, NOP,          32'h00000804, 32'h0,        1); // v11
    add(0, 0, 32'h0,        32'h0,        32'h0,        1,   1, 0, 0, NOP,          NOP,          32'h0,        32'h0,        0); // v12
    add(0, 2, 32'h30000000, 32'h30000001, 32'h00001000, 0,   1, 1, 1, 32'h30000000, 32'h30000001, 32'h00001000, 32'h00001004, 2); // v13 fill
    add(0, 2, 32'h30000002, 32'h30000003, 32'h00001008, 0,   1, 1, 1, 32'h30000000, 32'h30000001, 32'h00001000, 32'h00001004, 4); // v14
    add(0, 2, 32'h30000004, 32'h30000005, 32'h00001010, 0,   1, 1, 1, 32'h30000000, 32'h30000001, 32'h00001000, 32'h00001004, 6); // v15
    add(0, 2, 32'h30000006, 32'h30000007, 32'h00001018, 0,   0, 1, 1, 32'h30000000, 32'h30000001, 32'h00001000, 32'h00001004, 8); // v16 full
    add(0, 2, 32'hBBBB0001, 32'hBBBB0002, 32'h00002000, 0,   0, 1, 1, 32'h30000000, 32'h30000001, 32'h00001000, 32'h00001004, 8); // v17 dropped
    add(0, 2, 32'hBBBB0001, 32'hBBBB0002, 32'h00002000, 1,   0, 1, 1, 32'h30000001, 32'h30000002, 32'h00001004, 32'h00001008, 7); // v18
    add(0, 2, 32'hBBBB0001, 32'hBBBB0002, 32'h00002000, 2,   1, 1, 1, 32'h30000003, 32'h30000004, 32'h0000100C, 32'h00001010, 5); // v19 count=7 no enq
    add(0, 1, 32'h44440001, 32'h0,        32'h00003000, 0,   1, 1, 1, 32'h30000003, 32'h30000004, 32'h0000100C, 32'h00001010, 6); // v20
    add(0, 2, 32'h55550001, 32'h55550002, 32'h00004000, 2,   1, 1, 1, 32'h30000005, 32'h30000006, 32'h00001014, 32'h00001018, 6); // v21 enq2+deq2
    add(0, 0, 32'h0,        32'h0,        32'h0,        2,   1, 1, 1, 32'h30000007, 32'h44440001, 32'h0000101C, 32'h00003000, 4); // v22
    add(1, 2, 32'hCCCC0001, 32'hCCCC0002, 32'h00005000, 1,   1, 0, 0, NOP,          NOP,          32'h0,        32'h0,        0); // v23 flush
    add(0, 1, 32'h66660001, 32'h0,        32'h00006000, 0,   1, 1, 0, 32'h66660001, NOP,          32'h00006000, 32'h0,        1); // v24

    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.enq_cnt   = 2'd0;
    bus.enq_inst1 = 32'd0;
    bus.enq_inst2 = 32'd0;
    bus.enq_pc    = 32'd0;
    bus.deq_cnt   = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1, 0, 0, NOP, NOP, 32'h0, 32'h0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].flush, vecs[i].enq_cnt, vecs[i].i1, vecs[i].i2, vecs[i].pc, vecs[i].deq_cnt);
      check_all($sformatf("v%0d", i), vecs[i].e_ready, vecs[i].e_v1, vecs[i].e_v2, vecs[i].e_i1,
                vecs[i].e_i2, vecs[i].e_pc1, vecs[i].e_pc2, vecs[i].e_count);
    end

    // Changing enq/deq counts mid-cycle must not disturb outputs before the edge.
    bus.enq_cnt = 2'd2;
    bus.deq_cnt = 2'd2;
    #2;
    check_output("comb.count",  32'(bus.count),      32'd1);
    check_output("comb.valid1", 32'(bus.deq_valid1), 32'd1);
    check_output("comb.inst1",  bus.deq_inst1,       32'h66660001);
    check_output("comb.ready",  32'(bus.enq_ready),  32'd1);
    bus.enq_cnt = 2'd0;
    bus.deq_cnt = 2'd0;
    @(posedge clk);
    #1;
    check_all("hold", 1, 1, 0, 32'h66660001, NOP, 32'h00006000, 32'h0, 1);

    // Mid-stream reset drops the offered pair; an enqueue right after is visible one cycle later.
    reset = 1'b1;
    apply_stimulus(0, 2, 32'hDDDD0001, 32'hDDDD0002, 32'h00007000, 1);
    check_all("midreset", 1, 0, 0, NOP, NOP, 32'h0, 32'h0, 0);
    reset = 1'b0;
    apply_stimulus(0, 1, 32'h77770001, 32'h0, 32'h00007100, 0);
    check_all("postreset", 1, 1, 0, 32'h77770001, NOP, 32'h00007100, 32'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
# decode_queue

Two-wide instruction queue between the fetch stage and the pair of `decoder` instances. It buffers 0–2 fetched instructions per cycle with their PCs. It presents the oldest two to the decoders and retires 0–2 per cycle as dispatch accepts them. It absorbs dispatch stalls, back-pressures fetch, and is emptied on a branch-mispredict flush.

## Interface
- `DEPTH`, default 8: number of single-instruction entries; power of two, ≥4.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `flush`  in  1: kill all queued instructions (mispredict/exception redirect).
- `enq_cnt`  in  2: instructions offered by fetch this cycle; valid values 0, 1, 2.
- `enq_inst1`  in  32: older offered instruction.
- `enq_inst2`  in  32: younger offered instruction; meaningful only when `enq_cnt`==2.
- `enq_pc`  in  32: PC of `enq_inst1`; the PC of `enq_inst2` is `enq_pc`+4.
- `enq_ready`  out  1: the queue can accept up to 2 instructions this cycle.
- `deq_valid1`  out  1: head entry valid.
- `deq_valid2`  out  1: head+1 entry valid; never 1 while `deq_valid1` is 0.
- `deq_inst1`  out  32: head instruction; the NOP encoding 32'h00000013 when invalid.
- `deq_inst2`  out  32: head+1 instruction; 32'h00000013 when invalid.
- `deq_pc1`  out  32: head PC; 0 when invalid.
- `deq_pc2`  out  32: head+1 PC; 0 when invalid.
- `deq_cnt`  in  2: instructions consumed by dispatch this cycle; 0, 1, 2.
- `count`  out  $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage is a circular buffer of DEPTH entries, each holding {inst[31:0], pc[31:0]}.
  - `head` and `tail` pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` tracks occupancy separately, so full and empty are unambiguous.
- Enqueue:
  - Enqueue happens when `enq_ready`=1, `enq_cnt`∈{1,2} and `flush`=0.
  - `enq_inst1`/`enq_pc` are written to `tail`.
  - If `enq_cnt`=2, `enq_inst2`/`enq_pc`+4 are written to `tail`+1 (mod DEPTH).
  - `tail` advances by the number written.
- `enq_ready` = (`count` ≤ DEPTH−2).
  - It is computed from the current `count` only and ignores a same-cycle dequeue.
  - When `enq_ready`=0, the offered instructions are dropped; fetch must hold and re-offer them.
- `enq_cnt`=3 is illegal. It is treated as 0: nothing is written and pointers do not change.
- Dequeue:
  - The effective dequeue amount is min(`deq_cnt`, `deq_valid1`+`deq_valid2`). Over-requests are clamped and never underflow.
  - `head` advances by the effective amount.
- Output validity: `deq_valid1` = (`count`≥1); `deq_valid2` = (`count`≥2).
- Output data is read combinationally from the storage at `head` and `head`+1 (mod DEPTH), then masked to NOP/0 when the corresponding valid is low. The decoder therefore never sees stale or illegal bits.
- Same-cycle update: `count_next` = `count` + enq_eff − deq_eff.
- Flush:
  - `flush` has priority over enqueue and dequeue in the same cycle.
  - On the next edge, `head`=`tail`=0 and `count`=0.
  - All enqueue and dequeue effects of the flush cycle are discarded.
  - The storage contents are not cleared.
- Reset has the same effect as flush. In addition, all storage entries are set to {32'h00000013, 32'h0}.

## Timing
- Reset values of the outputs:
  - `enq_ready`=1.
  - `deq_valid1`=`deq_valid2`=0.
  - `deq_inst1`=`deq_inst2`=32'h00000013.
  - `deq_pc1`=`deq_pc2`=0.
  - `count`=0.
- Enqueue-to-visible latency is 1 cycle. An instruction written at edge N appears on the `deq_*` outputs in the cycle after edge N. There is no same-cycle bypass from enqueue to dequeue.
- Dequeue takes effect at the edge. The new head is visible in the following cycle.
- Full case, `count`=DEPTH−1: `enq_ready`=0 even if `deq_cnt`=2 in the same cycle.
- Wrap-around: a two-entry write at `tail`=DEPTH−1 writes entries DEPTH−1 and 0. A two-entry read at `head`=DEPTH−1 reads the same two entries.
- Reset or flush asserted mid-stream: the outputs are invalid in the following cycle. An enqueue in that following cycle becomes visible one cycle later.
- There are no combinational paths from `deq_cnt` or `enq_cnt` to any output.

## Test plan
- Reset, then enqueue 2 instructions (0x00500093, 0x00A00113) with `enq_pc`=0x100:
  - The next cycle shows `deq_valid1`=`deq_valid2`=1, `deq_pc1`=0x100, `deq_pc2`=0x104 and `count`=2.
- Fill test with DEPTH=8: enqueue pairs with `deq_cnt`=0.
  - After 4 pairs, `count`=8 and `enq_ready`=0.
  - A 5th pair offered is dropped, and `count` stays 8.
- Partial dequeue with 3 queued instructions A, B, C and `deq_cnt`=1:
  - The next cycle shows `deq_inst1`=B, `deq_inst2`=C and `count`=2.
  - Then `deq_cnt`=2 gives `count`=0 and both valids 0, with the insts reading 32'h00000013.
- Wrap-around: drive `head`/`tail` to 7 via enqueue and dequeue, then enqueue a pair X, Y.
  - X and Y are stored at entries 7 and 0.
  - They dequeue in order X then Y, with PCs base and base+4.
- Simultaneous events with `count`=6:
  - `enq_cnt`=2 with `deq_cnt`=2 gives `count`=6.
  - With `count`=4, `flush`=1, `enq_cnt`=2 and `deq_cnt`=1 in the same cycle, the next cycle has `count`=0, both valids 0 and `enq_ready`=1.
- Over-request: with `count`=1 and `deq_cnt`=2, the result is `count`=0 with no underflow.
- Illegal `enq_cnt`=3 leaves `count` unchanged.
